fc_dec_temporal: RTL and testbench
==================================

// Module: fc_dec_temporal
// PURPOSE
//  Fault countermeasure for the Ascon decryption path, using temporal redundancy.
//  - Runs one external Decryption core three times on the same inputs.
//  - Captures plaintext and auth flag from each run, then majority-votes the results.
//  - Releases plaintext only when the vote agrees and the tag verifies.
//  - Sits between the host and the decryption core; it is the decryption-side counterpart to the
//    encryption fault countermeasure.
// PARAMETERS
//  y            40    plaintext/ciphertext length in bits
//  TIMEOUT_CYC  256   max cycles per core run before declaring a fault
// PORTS
//  clk                     in   1  system clock
//  rst                     in   1  asynchronous, active-low reset
//  decryption_start        in   1  host request; rising edge accepted in IDLE/DONE
//  core_rst_n              out  1  core local reset, active-low; pulsed before each run
//  core_start              out  1  core start level; held high during RUN
//  core_plain_text         in   y  core plaintext result
//  core_auth               in   1  core tag-match flag
//  core_ready              in   1  core done level
//  random_fault            in   y  substitute output on unrecoverable fault
//  plain_text              out  y  voted plaintext; zero unless authenticated
//  message_authentication  out  1  voted tag-match result
//  fault_detect            out  1  runs disagreed or a core run timed out
//  decryption_ready        out  1  result valid; held until next accepted start
// BEHAVIOUR
//  Reset (rst=0):
//   - All outputs are 0, including core_rst_n (core held in reset).
//   - FSM is IDLE; run_idx=0; capture registers are 0.
//  Input stability: the host holds key/nonce/AD/ciphertext/tag stable from start until decryption_ready.
//   The block does not register them.
//  FSM:
//   - IDLE/DONE -> FLUSH on decryption_start rising edge (edge-detect register).
//     Entering FLUSH clears decryption_ready, fault_detect, plain_text and message_authentication.
//   - FLUSH (1 cycle): core_rst_n=0, core_start=0 -> RUN.
//   - RUN: core_start=1, tmo_cnt increments.
//     - core_ready=1 -> CAPTURE.
//     - tmo_cnt==TIMEOUT_CYC-1 -> VOTE with timeout flag set. Pending runs are not executed.
//   - CAPTURE (1 cycle):
//     - Store {core_auth, core_plain_text} into slot run_idx; core_start=0.
//     - run_idx==2 -> VOTE; else run_idx++ and -> FLUSH.
//   - VOTE (1 cycle): registered outputs update on exit.
//     - agree := any two slots identical (auth and pt both).
//     - If agree and no timeout:
//       - message_authentication = bitwise majority of the auth bits.
//       - plain_text = majority pt if authenticated, else 0.
//       - fault_detect = 0, even if one slot differs.
//     - Else: plain_text = random_fault, message_authentication = 0, fault_detect = 1.
//     - -> DONE with decryption_ready=1.
//   - DONE: outputs stable; decryption_ready stays 1.
//  Boundary cases:
//   - decryption_start high or edge outside IDLE/DONE: ignored.
//   - Start held high: one operation only (edge-triggered).
//   - Async reset mid-run: immediate return to reset state; no partial result is ever released.
//   - Unverified plaintext is never driven to plain_text.
//  Latency: start edge -> ready = 3*(Lc+2)+2 cycles, Lc = core latency from core_start to core_ready.
// CONFIGURATION
//  FC_DEC_EARLY_ABORT_EN:
//   - Defined: after the 2nd CAPTURE, if slots 0 and 1 agree, go straight to VOTE (2 runs).
//     Latency becomes 2*(Lc+2)+2.
//   - Undefined: always 3 runs.
// STRUCTURE
//  Package fc_dec_pkg:
//   - FSM state enum (IDLE, FLUSH, RUN, CAPTURE, VOTE, DONE).
//   - run index width; TIMEOUT counter width = $clog2(TIMEOUT_CYC).
//  Sub-module fc_maj3:
//   - Combinational 3-input bitwise majority over {auth, pt}.
//   - Outputs agree flag and voted word; instantiated once in VOTE datapath.
// TESTING
//  Bench: behavioural core model with Lc=10; error injection on a chosen run.
//  1. Clean run, auth=1, pt=40'h11_2233_4455 all runs
//     -> ready after 38 cycles; pt=40'h11_2233_4455; auth=1; fault=0.
//  2. Run 2 pt bit 0 flipped
//     -> pt=40'h11_2233_4455; auth=1; fault=0 (majority masks).
//  3. Runs return 3 distinct pts
//     -> pt=random_fault (40'hDEAD_BEEF_00); auth=0; fault=1.
//  4. All runs auth=0, pt=40'hAB
//     -> pt=0; auth=0; fault=0; ready=1.
//  5. core_ready never asserts, TIMEOUT_CYC=16
//     -> ready after 18 cycles from start edge; fault=1; pt=random_fault.
//  6. rst low during run 2, then new start
//     -> outputs 0 immediately; fresh 3-run operation completes correctly.
//     Also with FC_DEC_EARLY_ABORT_EN: scenario 1 gives ready after 26 cycles.

Source files
------------

// File: rtl/fc_dec_pkg.sv
// Shared types and constants for the temporal-redundancy decryption fault countermeasure.
package fc_dec_pkg;

    localparam int unsigned PT_W            = 40;
    localparam int unsigned TIMEOUT_CYC_DEF = 256;
    localparam int unsigned N_RUNS          = 3;
    localparam int unsigned RUN_IDX_W       = 2;

    // Legacy-compatible state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FLUSH   = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_VOTE    = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    // One captured core result
    typedef struct packed {
        logic            auth;
        logic [PT_W-1:0] pt;
    } slot_t;

    localparam int unsigned SLOT_W = $bits(slot_t);

    // Timeout counter width for a given cycle budget
    function automatic int unsigned tmo_width(input int unsigned cyc);
        return (cyc > 1) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/fc_dec_temporal_if.sv
// Host and decryption-core signals of the temporal fault countermeasure.
interface fc_dec_temporal_if;
    import fc_dec_pkg::*;

    logic            decryption_start;
    logic [PT_W-1:0] random_fault;
    logic [PT_W-1:0] plain_text;
    logic            message_authentication;
    logic            fault_detect;
    logic            decryption_ready;
    logic            core_rst_n;
    logic            core_start;
    logic [PT_W-1:0] core_plain_text;
    logic            core_auth;
    logic            core_ready;

    // Countermeasure view
    modport slave (
        input  decryption_start, random_fault, core_plain_text, core_auth, core_ready,
        output core_rst_n, core_start, plain_text, message_authentication,
               fault_detect, decryption_ready
    );

    // Host + core environment view
    modport master (
        output decryption_start, random_fault, core_plain_text, core_auth, core_ready,
        input  core_rst_n, core_start, plain_text, message_authentication,
               fault_detect, decryption_ready
    );

endinterface

// File: rtl/fc_maj3.sv
// Bitwise 2-of-3 majority over captured {auth, pt} words plus pairwise-agreement flag.
module fc_maj3 #(
    parameter int unsigned W = 41
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] vote_c,
    output logic         agree_c
);

    assign vote_c  = (a & b) | (a & c) | (b & c);
    assign agree_c = (a == b) || (a == c) || (b == c);

endmodule

// File: rtl/fc_dec_temporal.sv
// Temporal-redundancy fault countermeasure for the Ascon decryption core: runs the core
// three times on the same inputs, votes the results and releases plaintext only when
// the runs agree and the tag verifies.
// Optional: FC_DEC_EARLY_ABORT_EN skips the third run when the first two results match.
module fc_dec_temporal
    import fc_dec_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    fc_dec_temporal_if.slave   bus
);

    localparam int unsigned TMO_W = tmo_width(TIMEOUT_CYC);

    logic [2:0]           state, state_nxt;
    logic                 start_q;
    logic [RUN_IDX_W-1:0] run_idx, run_idx_nxt;
    logic [TMO_W-1:0]     tmo_cnt, tmo_cnt_nxt;
    logic                 tmo_flag, tmo_flag_nxt;
    slot_t                slot [N_RUNS];
    slot_t                slot_nxt [N_RUNS];
    logic                 core_rst_n_q, core_rst_n_nxt;
    logic                 core_start_q, core_start_nxt;
    logic [PT_W-1:0]      pt_q, pt_nxt;
    logic                 auth_q, auth_nxt;
    logic                 fault_q, fault_nxt;
    logic                 ready_q, ready_nxt;

    logic                 start_edge_c;
    logic                 early_c;
    slot_t                core_word_c;
    slot_t                vote_c;
    logic                 agree_c;

    assign start_edge_c = bus.decryption_start & ~start_q;
    assign core_word_c  = {bus.core_auth, bus.core_plain_text};

`ifdef FC_DEC_EARLY_ABORT_EN
    // Second capture matching the first already forms a majority
    assign early_c = (run_idx == RUN_IDX_W'(1)) && (slot[0] == core_word_c);
`else
    assign early_c = 1'b0;
`endif

    // Majority vote over the three captured slots
    fc_maj3 #(.W(SLOT_W)) u_maj3 (
        .a       (slot[0]),
        .b       (slot[1]),
        .c       (slot[2]),
        .vote_c  (vote_c),
        .agree_c (agree_c)
    );

    assign bus.core_rst_n             = core_rst_n_q;
    assign bus.core_start             = core_start_q;
    assign bus.plain_text             = pt_q;
    assign bus.message_authentication = auth_q;
    assign bus.fault_detect           = fault_q;
    assign bus.decryption_ready       = ready_q;

    // Next-state and next-output logic
    always_comb begin
        state_nxt      = state;
        run_idx_nxt    = run_idx;
        tmo_cnt_nxt    = tmo_cnt;
        tmo_flag_nxt   = tmo_flag;
        slot_nxt       = slot;
        core_rst_n_nxt = core_rst_n_q;
        core_start_nxt = core_start_q;
        pt_nxt         = pt_q;
        auth_nxt       = auth_q;
        fault_nxt      = fault_q;
        ready_nxt      = ready_q;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_edge_c) begin
                    state_nxt      = ST_FLUSH;
                    run_idx_nxt    = '0;
                    tmo_cnt_nxt    = '0;
                    tmo_flag_nxt   = 1'b0;
                    core_rst_n_nxt = 1'b0;
                    core_start_nxt = 1'b0;
                    pt_nxt         = '0;
                    auth_nxt       = 1'b0;
                    fault_nxt      = 1'b0;
                    ready_nxt      = 1'b0;
                end
            end
            ST_FLUSH: begin
                // Timeout window spans the flush cycle and the run
                state_nxt      = ST_RUN;
                core_rst_n_nxt = 1'b1;
                core_start_nxt = 1'b1;
                tmo_cnt_nxt    = tmo_cnt + TMO_W'(1);
            end
            ST_RUN: begin
                if (bus.core_ready) begin
                    state_nxt      = ST_CAPTURE;
                    core_start_nxt = 1'b0;
                end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                    state_nxt      = ST_VOTE;
                    tmo_flag_nxt   = 1'b1;
                    core_start_nxt = 1'b0;
                end else begin
                    tmo_cnt_nxt    = tmo_cnt + TMO_W'(1);
                end
            end
            ST_CAPTURE: begin
                for (int i = 0; i < int'(N_RUNS); i++) begin
                    if (run_idx == RUN_IDX_W'(i)) slot_nxt[i] = core_word_c;
                end
                if (run_idx == RUN_IDX_W'(N_RUNS - 1) || early_c) begin
                    state_nxt      = ST_VOTE;
                end else begin
                    state_nxt      = ST_FLUSH;
                    run_idx_nxt    = run_idx + RUN_IDX_W'(1);
                    tmo_cnt_nxt    = '0;
                    core_rst_n_nxt = 1'b0;
                end
            end
            ST_VOTE: begin
                if (agree_c && !tmo_flag) begin
                    auth_nxt  = vote_c.auth;
                    pt_nxt    = vote_c.auth ? vote_c.pt : '0;
                    fault_nxt = 1'b0;
                end else begin
                    auth_nxt  = 1'b0;
                    pt_nxt    = bus.random_fault;
                    fault_nxt = 1'b1;
                end
                ready_nxt = 1'b1;
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            start_q      <= 1'b0;
            run_idx      <= '0;
            tmo_cnt      <= '0;
            tmo_flag     <= 1'b0;
            for (int i = 0; i < int'(N_RUNS); i++) slot[i] <= '0;
            core_rst_n_q <= 1'b0;
            core_start_q <= 1'b0;
            pt_q         <= '0;
            auth_q       <= 1'b0;
            fault_q      <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state        <= state_nxt;
            start_q      <= bus.decryption_start;
            run_idx      <= run_idx_nxt;
            tmo_cnt      <= tmo_cnt_nxt;
            tmo_flag     <= tmo_flag_nxt;
            slot         <= slot_nxt;
            core_rst_n_q <= core_rst_n_nxt;
            core_start_q <= core_start_nxt;
            pt_q         <= pt_nxt;
            auth_q       <= auth_nxt;
            fault_q      <= fault_nxt;
            ready_q      <= ready_nxt;
        end
    end

endmodule

// File: tb/tb_fc_dec_temporal.sv
// Self-checking bench for fc_dec_temporal: behavioural decryption core (Lc=10) with
// per-run result tables, hang injection and a result/latency reference model.
module tb_fc_dec_temporal;
    import fc_dec_pkg::*;

    localparam int LC  = 10;
    localparam int TMO = 16;
`ifdef FC_DEC_EARLY_ABORT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    fc_dec_temporal_if bus ();

    fc_dec_temporal #(.TIMEOUT_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural core: per-run result table, ready in the LC-th cycle of core_start
    logic [40:0] tab [3];
    logic [40:0] cur_word = '0;
    int          run_n    = 0;
    int          run_base = 0;
    int          hang_run = -1;
    int          cnt      = 0;

    assign bus.core_plain_text = cur_word[39:0];
    assign bus.core_auth       = cur_word[40];
    assign bus.core_ready      = bus.core_start && (cnt >= LC - 1) &&
                                 ((run_n - run_base - 1) != hang_run);

    always @(posedge bus.core_start) begin
        run_n = run_n + 1;
        if ((run_n - run_base - 1) >= 0 && (run_n - run_base - 1) <= 2)
            cur_word = tab[run_n - run_base - 1];
    end

    always @(posedge clk) begin
        if (!bus.core_rst_n)      cnt <= 0;
        else if (bus.core_start)  cnt <= cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: runs happen in order; a hung run times out and ends the operation;
    // any two equal results win the vote.
    function automatic void predict(input logic [39:0] rf, output int lat,
                                    output logic [39:0] pt, output logic auth,
                                    output logic fault);
        int          runs;
        bit          tmo;
        bit          ok;
        logic [40:0] win;
        runs = 0;
        tmo  = 1'b0;
        ok   = 1'b1;
        win  = '0;
        lat  = 0;
        for (int k = 0; k < 3; k++) begin
            if (EARLY && k == 2 && tab[0] == tab[1]) break;
            if (k == hang_run) begin
                tmo = 1'b1;
                lat = 1 + k * (LC + 2) + TMO + 1;
                break;
            end
            runs++;
        end
        if (!tmo) lat = runs * (LC + 2) + 2;
        if (tab[0] == tab[1] || tab[0] == tab[2]) win = tab[0];
        else if (tab[1] == tab[2])                win = tab[1];
        else                                      ok  = 1'b0;
        if (tmo || !ok) begin
            pt = rf; auth = 1'b0; fault = 1'b1;
        end else begin
            auth = win[40]; pt = win[40] ? win[39:0] : 40'h0; fault = 1'b0;
        end
    endfunction

    task automatic do_op(input string name, input logic [39:0] rf, input bit glitch);
        int          lat_e;
        int          cyc;
        int          runs_before;
        logic [39:0] pt_e;
        logic        au_e;
        logic        fl_e;
        predict(rf, lat_e, pt_e, au_e, fl_e);
        run_base = run_n;
        bus.random_fault = rf;
        @(posedge clk); #1;
        bus.decryption_start = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                check({name, ":busy_ready"}, 64'(bus.decryption_ready), 64'(0));
                check({name, ":busy_pt"},    64'(bus.plain_text),       64'(0));
                check({name, ":busy_fault"}, 64'(bus.fault_detect),     64'(0));
            end
            if (glitch && cyc == 4) bus.decryption_start = 1'b0;
            if (glitch && cyc == 7) bus.decryption_start = 1'b1;
        end while (!bus.decryption_ready && cyc < 2000);
        check({name, ":latency"}, 64'(cyc),                        64'(lat_e));
        check({name, ":pt"},      64'(bus.plain_text),             64'(pt_e));
        check({name, ":auth"},    64'(bus.message_authentication), 64'(au_e));
        check({name, ":fault"},   64'(bus.fault_detect),           64'(fl_e));
        // Start held high: result stays, no further core runs
        runs_before = run_n;
        repeat (30) @(posedge clk);
        #1;
        check({name, ":hold_ready"}, 64'(bus.decryption_ready), 64'(1));
        check({name, ":no_rerun"},   64'(run_n),                64'(runs_before));
        check({name, ":hold_pt"},    64'(bus.plain_text),       64'(pt_e));
        bus.decryption_start = 1'b0;
        @(posedge clk);
    endtask

    task automatic check_zero(input string name);
        check({name, ":ready"},      64'(bus.decryption_ready),       64'(0));
        check({name, ":pt"},         64'(bus.plain_text),             64'(0));
        check({name, ":auth"},       64'(bus.message_authentication), 64'(0));
        check({name, ":fault"},      64'(bus.fault_detect),           64'(0));
        check({name, ":core_rst_n"}, 64'(bus.core_rst_n),             64'(0));
        check({name, ":core_start"}, 64'(bus.core_start),             64'(0));
    endtask

    initial begin
        logic [40:0] base;
        logic [40:0] m1;
        logic [40:0] m2;
        logic [39:0] rf;
        int          kind;
        int          a;
        int          b;
        int          k;
        int          i;

        bus.decryption_start = 1'b0;
        bus.random_fault     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;

        // 1: clean
        for (int j = 0; j < 3; j++) tab[j] = {1'b1, 40'h11_2233_4455};
        do_op("clean", 40'hDE_ADBE_EF00, 1'b0);
        // 2: second run bit 0 flipped
        tab[1] = {1'b1, 40'h11_2233_4454};
        do_op("one_bad", 40'hDE_ADBE_EF00, 1'b0);
        // 3: three distinct results
        tab[0] = {1'b1, 40'h11_2233_4455};
        tab[1] = {1'b1, 40'h11_2233_4456};
        tab[2] = {1'b1, 40'h11_2233_4457};
        do_op("distinct", 40'hDE_ADBE_EF00, 1'b0);
        // 4: tag mismatch on every run
        for (int j = 0; j < 3; j++) tab[j] = {1'b0, 40'hAB};
        do_op("noauth", 40'hDE_ADBE_EF00, 1'b0);
        // 5: core never finishes
        for (int j = 0; j < 3; j++) tab[j] = {1'b1, 40'h11_2233_4455};
        hang_run = 0;
        do_op("timeout", 40'hDE_ADBE_EF00, 1'b0);
        hang_run = -1;

        // 6: async reset during the second run, then a fresh operation
        run_base = run_n;
        @(posedge clk); #1;
        bus.decryption_start = 1'b1;
        i = 0;
        while ((run_n - run_base) < 2 && i < 200) begin
            @(posedge clk);
            i++;
        end
        check("rst_mid:reached_run2", 64'(run_n - run_base), 64'(2));
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_zero("rst_mid");
        bus.decryption_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst_hold");
        rst = 1'b1;
        tab[0] = {1'b1, 40'h12_3456_789A};
        tab[1] = tab[0];
        tab[2] = tab[0];
        do_op("after_rst", 40'h55_AA55_AA55, 1'b0);

        // Randomized operations
        for (int it = 0; it < 24; it++) begin
            kind = int'($urandom_range(0, 4));
            base = {1'($urandom), 40'({$urandom, $urandom})};
            rf   = 40'({$urandom, $urandom});
            for (int j = 0; j < 3; j++) tab[j] = base;
            hang_run = -1;
            case (kind)
                1: begin
                    k = int'($urandom_range(0, 2));
                    tab[k] = base ^ (41'(1) << $urandom_range(0, 40));
                end
                2: begin
                    a  = int'($urandom_range(0, 40));
                    b  = (a + 1 + int'($urandom_range(0, 39))) % 41;
                    m1 = 41'(1) << a;
                    m2 = 41'(1) << b;
                    tab[1] = base ^ m1;
                    tab[2] = base ^ m2;
                end
                3: begin
                    for (int j = 0; j < 3; j++) tab[j][40] = 1'b0;
                end
                4: hang_run = int'($urandom_range(0, 2));
                default: ;
            endcase
            do_op($sformatf("rand%0d_k%0d", it, kind), rf, (it % 5) == 0);
        end
        hang_run = -1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
